// File: rtl/fuse_loader.sv
// fuse_loader: accepts a byte-wide JEDEC-style fuse stream over valid/ready,
// unpacks it into a registered fuse array, and verifies it against a
// trailing little-endian 16-bit sum of the data bytes.
module fuse_loader #(
    parameter int FUSE_BITS = 16808,
    parameter int GMUX_BASE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [FUSE_BITS-1:0] fuses,
    output logic [45:0]          global_mux,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [15:0]          checksum
);

    localparam int NBYTES = (FUSE_BITS + 7) / 8;
    localparam int CW     = $clog2(NBYTES + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, CHK_LO, CHK_HI, DONE, ERROR
    } state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic [15:0]    expected;
    logic           accept;
    logic           clear;
    logic           last_byte;

    assign accept    = in_valid && in_ready;
    // start only has an effect while no load is in flight
    assign clear     = start && (state inside {IDLE, DONE, ERROR});
    assign last_byte = (cnt == CW'(NBYTES - 1));

    // next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERROR: if (start) state_nx = LOAD;
            LOAD:              if (accept && last_byte) state_nx = CHK_LO;
            CHK_LO:            if (accept) state_nx = CHK_HI;
            CHK_HI:            if (accept)
                                   state_nx = ({in_data, expected[7:0]} == checksum) ? DONE : ERROR;
            default:           state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // in_ready is registered from the next state so it lines up with the state it belongs to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_ready <= 1'b0;
        else        in_ready <= (state_nx inside {LOAD, CHK_LO, CHK_HI});
    end

    // byte counter, running sum (padding bits included) and trailer capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            checksum <= '0;
            expected <= '0;
        end else if (clear) begin
            cnt      <= '0;
            checksum <= '0;
            expected <= '0;
        end else if (accept) begin
            case (state)
                LOAD: begin
                    cnt      <= cnt + CW'(1);
                    checksum <= checksum + 16'(in_data);
                end
                CHK_LO:  expected[7:0]  <= in_data;
                CHK_HI:  expected[15:8] <= in_data;
                default: ;
            endcase
        end
    end

    // one register slice per stream byte; the final slice keeps only the real fuse bits
    for (genvar k = 0; k < NBYTES; k++) begin : g_byte
        localparam int W = (FUSE_BITS - 8 * k >= 8) ? 8 : (FUSE_BITS - 8 * k);
        logic wr;
        assign wr = accept && (state == LOAD) && (cnt == CW'(k));

        // capture byte k when it is accepted; cleared by a new load
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)     fuses[8*k +: W] <= '0;
            else if (clear) fuses[8*k +: W] <= '0;
            else if (wr)    fuses[8*k +: W] <= in_data[W-1:0];
        end
    end

    assign global_mux = fuses[GMUX_BASE +: 46];
    assign busy       = (state inside {LOAD, CHK_LO, CHK_HI});
    assign done       = (state == DONE);
    assign error      = (state == ERROR);

endmodule

// File: tb/tb_fuse_loader.sv
// Bench for fuse_loader: a 64-fuse instance for handshake/checksum scenarios
// and a 2060-fuse instance for the partial-last-byte and wrap cases.
module tb_fuse_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // small instance
    logic        a_start, a_valid, a_ready, a_busy, a_done, a_error;
    logic [7:0]  a_data;
    logic [63:0] a_fuses;
    logic [45:0] a_gmux;
    logic [15:0] a_sum;

    // large instance
    logic          b_start, b_valid, b_ready, b_busy, b_done, b_error;
    logic [7:0]    b_data;
    logic [2059:0] b_fuses;
    logic [45:0]   b_gmux;
    logic [15:0]   b_sum;

    int cmp = 0;
    int mis = 0;

    fuse_loader #(.FUSE_BITS(64), .GMUX_BASE(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_ready), .fuses(a_fuses), .global_mux(a_gmux), .busy(a_busy),
        .done(a_done), .error(a_error), .checksum(a_sum));

    fuse_loader #(.FUSE_BITS(2060), .GMUX_BASE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .fuses(b_fuses), .global_mux(b_gmux), .busy(b_busy),
        .done(b_done), .error(b_error), .checksum(b_sum));

    task automatic push_a(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            int n = $urandom_range(0, 2);
            repeat (n) begin
                a_valid = 1'b0;
                a_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        a_data  = b;
        a_valid = 1'b1;
        for (int g = 0; g < 20 && !a_ready; g++) begin
            @(posedge clk); #1;
        end
        if (!a_ready) begin
            cmp++; mis++;
            $display("FAIL push_a_timeout: in_ready=%b required 1", a_ready);
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        a_data  = 8'($urandom);
    endtask

    task automatic push_b(input logic [7:0] b);
        b_data  = b;
        b_valid = 1'b1;
        for (int g = 0; g < 20 && !b_ready; g++) begin
            @(posedge clk); #1;
        end
        if (!b_ready) begin
            cmp++; mis++;
            $display("FAIL push_b_timeout: in_ready=%b required 1", b_ready);
        end
        @(posedge clk); #1;
        b_valid = 1'b0;
    endtask

    // full load on the small instance, checked against a byte-array model
    task automatic run_a(input string name, input logic [7:0] d[8], input logic [15:0] trl,
                         input bit gaps, input int start_at);
        logic [63:0] m_f;
        logic [15:0] m_sum;
        bit          m_ok;
        m_sum = 16'h0;
        for (int k = 0; k < 8; k++) begin
            m_f[8*k +: 8] = d[k];
            m_sum = m_sum + 16'(d[k]);
        end
        m_ok = (trl == m_sum);

        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        cmp++;
        if (a_fuses !== 64'h0 || a_sum !== 16'h0 || a_done !== 1'b0 || a_error !== 1'b0
            || a_ready !== 1'b1 || a_busy !== 1'b1) begin
            mis++;
            $display("FAIL %s_start_clear: fuses=%h sum=%h done=%b err=%b rdy=%b busy=%b required 0/0/0/0/1/1",
                     name, a_fuses, a_sum, a_done, a_error, a_ready, a_busy);
        end

        for (int k = 0; k < 8; k++) begin
            push_a(d[k], gaps);
            if (k == start_at) begin
                a_start = 1'b1;
                @(posedge clk); #1;
                a_start = 1'b0;
                cmp++;
                if (a_busy !== 1'b1 || a_ready !== 1'b1) begin
                    mis++;
                    $display("FAIL %s_start_ignored: busy=%b rdy=%b required 1/1", name, a_busy, a_ready);
                end
            end
        end
        push_a(trl[7:0], gaps);
        cmp++;
        if (a_done !== 1'b0 || a_busy !== 1'b1 || a_sum !== m_sum) begin
            mis++;
            $display("FAIL %s_mid_chk: done=%b busy=%b sum=%h required 0/1/%h", name, a_done, a_busy, a_sum, m_sum);
        end
        push_a(trl[15:8], gaps);

        cmp++;
        if (a_done !== m_ok || a_error !== !m_ok) begin
            mis++;
            $display("FAIL %s_flags: done=%b err=%b required %b/%b", name, a_done, a_error, m_ok, !m_ok);
        end
        cmp++;
        if (a_sum !== m_sum) begin
            mis++;
            $display("FAIL %s_checksum: got %h required %h", name, a_sum, m_sum);
        end
        cmp++;
        if (a_fuses !== m_f || a_gmux !== m_f[8 +: 46]) begin
            mis++;
            $display("FAIL %s_fuses: got %h gmux %h required %h gmux %h", name, a_fuses, a_gmux, m_f, m_f[8 +: 46]);
        end
        cmp++;
        if (a_ready !== 1'b0 || a_busy !== 1'b0) begin
            mis++;
            $display("FAIL %s_idle_out: rdy=%b busy=%b required 0/0", name, a_ready, a_busy);
        end
        // result must hold while idle, even with stray valid bytes
        a_valid = 1'b1;
        a_data  = 8'($urandom);
        repeat (3) begin
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        cmp++;
        if (a_done !== m_ok || a_fuses !== m_f || a_sum !== m_sum) begin
            mis++;
            $display("FAIL %s_hold: done=%b fuses=%h sum=%h required %b/%h/%h", name, a_done, a_fuses, a_sum, m_ok, m_f, m_sum);
        end
    endtask

    task automatic test_reset();
        cmp++;
        if (a_ready !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0 || a_error !== 1'b0
            || a_sum !== 16'h0 || a_fuses !== 64'h0 || a_gmux !== 46'h0) begin
            mis++;
            $display("FAIL reset_a: rdy=%b busy=%b done=%b err=%b sum=%h fuses=%h required all 0",
                     a_ready, a_busy, a_done, a_error, a_sum, a_fuses);
        end
        cmp++;
        if (b_ready !== 1'b0 || b_busy !== 1'b0 || b_done !== 1'b0 || b_sum !== 16'h0 || b_fuses !== '0) begin
            mis++;
            $display("FAIL reset_b: rdy=%b busy=%b done=%b sum=%h required all 0", b_ready, b_busy, b_done, b_sum);
        end
    endtask

    task automatic test_basic();
        logic [7:0] d[8];
        for (int k = 0; k < 8; k++) d[k] = 8'(k + 1);
        run_a("basic", d, 16'h0024, 1'b0, -1);
    endtask

    task automatic test_bad_trailer();
        logic [7:0] d[8];
        for (int k = 0; k < 8; k++) d[k] = 8'(k + 1);
        run_a("bad_trl", d, 16'h0025, 1'b0, -1);
        run_a("reload", d, 16'h0024, 1'b0, -1);
    endtask

    task automatic test_gaps();
        logic [7:0] d[8];
        for (int k = 0; k < 8; k++) d[k] = 8'(k + 1);
        run_a("gaps", d, 16'h0024, 1'b1, -1);
    endtask

    task automatic test_start_mid();
        logic [7:0] d[8];
        for (int k = 0; k < 8; k++) d[k] = 8'(k + 1);
        run_a("start_mid", d, 16'h0024, 1'b0, 2);
    endtask

    task automatic test_random();
        logic [7:0]  d[8];
        logic [15:0] s;
        logic [15:0] trl;
        for (int it = 0; it < 16; it++) begin
            s = 16'h0;
            for (int k = 0; k < 8; k++) begin
                d[k] = 8'($urandom);
                s = s + 16'(d[k]);
            end
            trl = ($urandom_range(0, 1) == 1) ? s : (s ^ 16'(1 << $urandom_range(0, 15)));
            run_a("random", d, trl, ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1);
        end
    endtask

    // 258-byte stream; last byte carries only 4 real fuse bits
    task automatic test_big(input bit all_ff);
        logic [7:0]    d[258];
        logic [2059:0] m_f;
        logic [15:0]   m_sum;
        m_sum = 16'h0;
        m_f   = '0;
        for (int k = 0; k < 258; k++) begin
            d[k]  = all_ff ? 8'hFF : 8'($urandom);
            m_sum = m_sum + 16'(d[k]);
            for (int i = 0; i < 8; i++)
                if (8 * k + i < 2060) m_f[8*k + i] = d[k][i];
        end
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        for (int k = 0; k < 258; k++) push_b(d[k]);
        if (all_ff) begin
            cmp++;
            if (m_sum !== 16'h00FE) begin
                mis++;
                $display("FAIL big_model_sum: got %h required 00fe", m_sum);
            end
        end
        push_b(m_sum[7:0]);
        push_b(m_sum[15:8]);
        cmp++;
        if (b_done !== 1'b1 || b_error !== 1'b0 || b_sum !== m_sum) begin
            mis++;
            $display("FAIL big_result: done=%b err=%b sum=%h required 1/0/%h", b_done, b_error, b_sum, m_sum);
        end
        cmp++;
        if (b_fuses !== m_f || b_gmux !== m_f[45:0]) begin
            mis++;
            $display("FAIL big_fuses: %0d bits differ, gmux=%h required %h",
                     $countones(b_fuses ^ m_f), b_gmux, m_f[45:0]);
        end
    endtask

    task automatic test_async_reset();
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        for (int k = 0; k < 5; k++) push_a(8'(k + 1), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        cmp++;
        if (a_ready !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0 || a_error !== 1'b0
            || a_sum !== 16'h0 || a_fuses !== 64'h0 || a_gmux !== 46'h0) begin
            mis++;
            $display("FAIL async_reset: rdy=%b busy=%b done=%b err=%b sum=%h fuses=%h required all 0",
                     a_ready, a_busy, a_done, a_error, a_sum, a_fuses);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        cmp++;
        if (a_ready !== 1'b0 || a_busy !== 1'b0 || a_sum !== 16'h0 || a_fuses !== 64'h0) begin
            mis++;
            $display("FAIL post_reset_idle: rdy=%b busy=%b sum=%h fuses=%h required 0", a_ready, a_busy, a_sum, a_fuses);
        end
        test_basic();
    endtask

    initial begin
        a_start = 1'b0; a_valid = 1'b0; a_data = 8'h0;
        b_start = 1'b0; b_valid = 1'b0; b_data = 8'h0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_bad_trailer();
        test_gaps();
        test_start_mid();
        test_random();
        test_big(1'b1);
        test_big(1'b0);
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end

endmodule

// File: doc/fuse_loader.md
Name: fuse_loader

Overview:
- Configuration loader directly upstream of the atf1502 device model.
- Accepts a byte-wide JEDEC-style fuse stream over a valid/ready handshake and unpacks it into a registered fuse array.
- Verifies the stream against a trailing 16-bit fuse checksum.
- Presents the array, and the global_mux slice that feeds atf1502, with a config-valid flag.

Parameters:
- FUSE_BITS, 16808: total fuse count of the device array.
- GMUX_BASE, 0: fuse index of global_mux[0]. Requires GMUX_BASE+46 <= FUSE_BITS.
- NBYTES, derived ((FUSE_BITS+7)/8): number of data bytes in the stream. Localparam, not overridable.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a new load.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts in_data this cycle.
- fuses  output  FUSE_BITS  fuse array; fuses[8k+i] = bit i of data byte k.
- global_mux  output  46  fuses[GMUX_BASE +: 46], bit 0 at lowest fuse index.
- busy  output  1  high in LOAD or CHK.
- done  output  1  load completed with matching checksum; config valid.
- error  output  1  load completed with checksum mismatch.
- checksum  output  16  running mod-2^16 sum of accepted data bytes.

Behaviour:
- Reset (async, rst_n low) clears fuses, checksum, internal byte counter, expected-checksum register, in_ready, busy, done and error to 0. State goes to IDLE.
  - Reset mid-load aborts immediately; no partial state survives.
- A byte is accepted on a rising edge where in_valid and in_ready are both high. in_ready is registered.
- IDLE:
  - in_ready=0.
  - start -> LOAD next cycle. Same edge clears fuses, checksum, byte counter, done and error.
- LOAD:
  - in_ready=1, busy=1.
  - Each accepted byte k (counter 0..NBYTES-1):
    - writes fuses[8k+i] = in_data[i] for all i with 8k+i < FUSE_BITS;
    - adds the full 8-bit byte, padding bits included, to checksum mod 2^16;
    - increments the counter.
  - Padding bits beyond FUSE_BITS are never stored.
  - Accepting byte NBYTES-1 -> CHK_LO.
- CHK_LO:
  - in_ready=1.
  - Accepted byte becomes expected[7:0] -> CHK_HI.
- CHK_HI:
  - in_ready=1.
  - Accepted byte becomes expected[15:8].
  - Compare {in_data, expected[7:0]} with checksum.
    - Equal: done=1 on the following cycle, state DONE.
    - Unequal: error=1 on the following cycle, state ERROR.
  - in_ready drops to 0 that same following cycle.
- DONE / ERROR:
  - in_ready=0, busy=0.
  - Flags and fuses hold until start or reset.
  - start behaves as in IDLE: flags clear, state -> LOAD.
- start while busy is ignored; the load continues unaffected.
- in_valid gaps (in_valid low) stall with no state change. Inputs with in_valid low are don't-care.
- Latency: done/error assert exactly 1 cycle after the second checksum byte is accepted.
- fuses and global_mux update in the cycle after each accepted byte. Consumers must qualify them with done.
- Checksum wraps silently at 2^16. The counter never exceeds NBYTES.

Test Plan:
1. FUSE_BITS=64, GMUX_BASE=8.
   - Stimulus: start, then bytes 0x01..0x08, then 0x24, 0x00.
   - Required: done=1 one cycle after the last byte; error=0; checksum=0x0024; fuses byte k = k+1; global_mux = fuses[8:53]; in_ready=0; busy=0.
2. Same data as scenario 1, trailer 0x25, 0x00.
   - Required: error=1, done=0, checksum=0x0024, fuses retained.
   - Then a fresh start clears error; a correct reload gives done=1.
3. FUSE_BITS=2060 (258 bytes), all bytes 0xFF.
   - Stimulus: trailer 0xFE, 0x00.
   - Required: done=1 (checksum wrapped to 0x00FE); all 2060 fuses = 1; no write beyond index 2059.
4. FUSE_BITS=64.
   - Stimulus: in_valid toggled 1,0,0,1 pseudo-randomly across the load.
   - Required: identical result to scenario 1; no byte lost or duplicated.
5. Start pulsed during LOAD after byte 3.
   - Required: ignored; load completes with done=1.
6. rst_n dropped asynchronously after byte 5.
   - Required: all outputs 0 immediately (before the next clock edge); after release, state IDLE and in_ready=0 until start.
